coef_load_ctrl: RTL and testbench

Controller that sequences the 8-entry coefficient register bank feeding the systolic array. It accepts coefficients over a valid/ready stream and writes them into consecutive bank slots through the bank's enable/select/data port. Once all slots are filled it waits for a start command, then drives a read index sweep so the array consumes the coefficients in order, and returns to loading.

---
 rtl/coef_load_ctrl_pkg.sv | 16 +
 rtl/coef_ptr_cnt.sv | 37 +++
 rtl/coef_load_ctrl.sv | 163 ++++++++++++++++
 tb/tb_coef_load_ctrl.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/coef_load_ctrl_pkg.sv
// Shared definitions for the coefficient load controller: controller states
// and default bank geometry.
package coef_load_ctrl_pkg;

  localparam int COEF_DATA_W = 8;
  localparam int COEF_DEPTH  = 8;
  localparam int COEF_SEL_W  = 3;
  localparam int COEF_REP_W  = 3;

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_FULL  = 2'd1,
    ST_DRAIN = 2'd2
  } coef_state_e;

endpackage

// File: rtl/coef_ptr_cnt.sv
// Wrapping slot-index counter with synchronous clear (priority) and increment.
// Used for both the bank write pointer and the drain read pointer.
module coef_ptr_cnt #(
  parameter int SEL_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  output logic [SEL_W-1:0] cnt
);

  logic [SEL_W-1:0] cnt_q;
  logic [SEL_W-1:0] cnt_d;

  // Next count: clear beats increment; natural wrap at 2**SEL_W.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc) begin
      cnt_d = cnt_q + SEL_W'(1);
    end
  end

  // Count register, asynchronously returned to slot 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/coef_load_ctrl.sv
// Coefficient bank load/drain controller.
// Fills DEPTH bank slots from a valid/ready stream, waits for start, then
// sweeps the read index across the bank once per pass.
// Optional feature macro: COEF_CTRL_REPEAT_EN adds rep_cnt (extra passes).
module coef_load_ctrl
  import coef_load_ctrl_pkg::*;
#(
  parameter int DATA_W = COEF_DATA_W,
  parameter int DEPTH  = COEF_DEPTH,
  parameter int SEL_W  = COEF_SEL_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  s_valid,
  input  logic [DATA_W-1:0]     s_data,
  output logic                  s_ready,
  input  logic                  start,
`ifdef COEF_CTRL_REPEAT_EN
  input  logic [COEF_REP_W-1:0] rep_cnt,
`endif
  output logic                  bank_en,
  output logic [SEL_W-1:0]      bank_sel,
  output logic [DATA_W-1:0]     bank_din,
  output logic [SEL_W-1:0]      rd_sel,
  output logic                  rd_valid,
  output logic                  loaded,
  output logic                  busy,
  output logic                  done
);

  localparam logic [SEL_W-1:0] LAST_SLOT = SEL_W'(DEPTH - 1);

  coef_state_e           state_q;
  logic                  bank_en_q;
  logic [SEL_W-1:0]      bank_sel_q;
  logic [DATA_W-1:0]     bank_din_q;
  logic [SEL_W-1:0]      rd_sel_q;
  logic                  rd_valid_q;
  logic                  loaded_q;
  logic                  busy_q;
  logic                  done_q;
  logic [COEF_REP_W-1:0] pass_q;

  logic [SEL_W-1:0]      wr_ptr;
  logic [SEL_W-1:0]      rd_ptr;
  logic [COEF_REP_W-1:0] pass_init;
  logic                  accept;
  logic                  drain_start;
  logic                  drain_last;
  logic                  rd_adv;

`ifdef COEF_CTRL_REPEAT_EN
  assign pass_init = rep_cnt;
`else
  assign pass_init = '0;
`endif

  // Only LOAD takes beats, and an abort in the same cycle blocks them.
  assign s_ready     = (state_q == ST_LOAD) && !clear;
  assign accept      = s_valid && s_ready;
  assign drain_start = (state_q == ST_FULL) && start && !clear;
  // Final read of the final pass is on the bank interface right now.
  assign drain_last  = (state_q == ST_DRAIN) && (rd_sel_q == LAST_SLOT) && (pass_q == '0);
  // rd_ptr always holds the slot to present on the following cycle.
  assign rd_adv      = !clear && (drain_start || ((state_q == ST_DRAIN) && !drain_last));

  coef_ptr_cnt #(.SEL_W(SEL_W)) u_wr_ptr (
    .clk   (clk),
    .reset (reset),
    .clr   (clear),
    .inc   (accept),
    .cnt   (wr_ptr)
  );

  coef_ptr_cnt #(.SEL_W(SEL_W)) u_rd_ptr (
    .clk   (clk),
    .reset (reset),
    .clr   (clear),
    .inc   (rd_adv),
    .cnt   (rd_ptr)
  );

  // Controller FSM with all bank/read/status outputs registered.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_LOAD;
      bank_en_q  <= 1'b0;
      bank_sel_q <= '0;
      bank_din_q <= '0;
      rd_sel_q   <= '0;
      rd_valid_q <= 1'b0;
      loaded_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= '0;
    end else if (clear) begin
      // Bank contents stay put; only the bookkeeping is invalidated.
      state_q    <= ST_LOAD;
      bank_en_q  <= 1'b0;
      rd_sel_q   <= '0;
      rd_valid_q <= 1'b0;
      loaded_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= '0;
    end else begin
      bank_en_q <= 1'b0;
      done_q    <= 1'b0;
      case (state_q)
        ST_LOAD: begin
          if (accept) begin
            bank_en_q  <= 1'b1;
            bank_sel_q <= wr_ptr;
            bank_din_q <= s_data;
            if (wr_ptr == LAST_SLOT) begin
              state_q  <= ST_FULL;
              loaded_q <= 1'b1;
            end
          end
        end
        ST_FULL: begin
          if (drain_start) begin
            state_q    <= ST_DRAIN;
            busy_q     <= 1'b1;
            rd_valid_q <= 1'b1;
            rd_sel_q   <= rd_ptr;
            pass_q     <= pass_init;
          end
        end
        ST_DRAIN: begin
          if (drain_last) begin
            state_q    <= ST_LOAD;
            busy_q     <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_sel_q   <= '0;
            loaded_q   <= 1'b0;
            done_q     <= 1'b1;
          end else begin
            // Next pass starts at slot 0 with no idle cycle in between.
            if (rd_sel_q == LAST_SLOT) begin
              pass_q <= pass_q - COEF_REP_W'(1);
            end
            rd_sel_q <= rd_ptr;
          end
        end
        default: begin
          state_q <= ST_LOAD;
        end
      endcase
    end
  end

  assign bank_en  = bank_en_q;
  assign bank_sel = bank_sel_q;
  assign bank_din = bank_din_q;
  assign rd_sel   = rd_sel_q;
  assign rd_valid = rd_valid_q;
  assign loaded   = loaded_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_coef_load_ctrl.sv
// Self-checking bench for coef_load_ctrl: directed scenarios with literal
// expectations plus randomized traffic checked every cycle against a
// transaction-level model (slots filled, reads remaining).
module tb_coef_load_ctrl;

  localparam int DW    = 8;
  localparam int DEPTH = 8;
  localparam int SW    = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          clear;
  logic          s_valid;
  logic [DW-1:0] s_data;
  logic          s_ready;
  logic          start;
`ifdef COEF_CTRL_REPEAT_EN
  logic [2:0]    rep_cnt;
`endif
  logic          bank_en;
  logic [SW-1:0] bank_sel;
  logic [DW-1:0] bank_din;
  logic [SW-1:0] rd_sel;
  logic          rd_valid;
  logic          loaded;
  logic          busy;
  logic          done;

  int total = 0;
  int bad   = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  coef_load_ctrl dut (
    .clk      (clk),
    .reset    (reset),
    .clear    (clear),
    .s_valid  (s_valid),
    .s_data   (s_data),
    .s_ready  (s_ready),
    .start    (start),
`ifdef COEF_CTRL_REPEAT_EN
    .rep_cnt  (rep_cnt),
`endif
    .bank_en  (bank_en),
    .bank_sel (bank_sel),
    .bank_din (bank_din),
    .rd_sel   (rd_sel),
    .rd_valid (rd_valid),
    .loaded   (loaded),
    .busy     (busy),
    .done     (done)
  );

  // ---------------- behavioural model ----------------
  int m_filled;   // beats accepted into the current set
  bit m_full;     // a complete set is in the bank (through the drain)
  int m_left;     // reads still to be issued in this drain
  int m_total;    // reads scheduled for this drain
  bit m_en;
  bit m_done;
  int m_sel;
  int m_din;

  function automatic int passes_now();
`ifdef COEF_CTRL_REPEAT_EN
    return int'(rep_cnt) + 1;
`else
    return 1;
`endif
  endfunction

  function automatic void model_reset();
    m_filled = 0; m_full = 0; m_left = 0; m_total = 0;
    m_en = 0; m_done = 0; m_sel = 0; m_din = 0;
  endfunction

  function automatic void model_step();
    m_en   = 0;
    m_done = 0;
    if (!reset) begin
      model_reset();
    end else if (clear) begin
      m_filled = 0; m_full = 0; m_left = 0; m_total = 0;
    end else if (!m_full) begin
      if (s_valid) begin
        m_en  = 1;
        m_sel = m_filled;
        m_din = int'(s_data);
        m_filled++;
        if (m_filled == DEPTH) begin
          m_full   = 1;
          m_filled = 0;
        end
      end
    end else if (m_left == 0) begin
      if (start) begin
        m_total = DEPTH * passes_now();
        m_left  = m_total;
      end
    end else begin
      m_left--;
      if (m_left == 0) begin
        m_done = 1;
        m_full = 0;
      end
    end
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("s_ready", 32'(s_ready), 32'(!m_full && !clear));
      chk("bank_en", 32'(bank_en), 32'(m_en));
      if (m_en) begin
        chk("bank_sel", 32'(bank_sel), 32'(m_sel));
        chk("bank_din", 32'(bank_din), 32'(m_din));
        $display("write slot %0d data 0x%02h", m_sel, m_din);
      end
      chk("rd_valid", 32'(rd_valid), 32'(m_left > 0));
      chk("rd_sel", 32'(rd_sel), (m_left > 0) ? 32'((m_total - m_left) % DEPTH) : 32'd0);
      chk("loaded", 32'(loaded), 32'(m_full));
      chk("busy", 32'(busy), 32'(m_left > 0));
      chk("done", 32'(done), 32'(m_done));
      if (m_done) $display("drain complete at %0t", $time);
    end
  end

  task automatic load_random_set();
    for (int i = 0; i < DEPTH; i++) begin
      s_valid = 1'b1;
      s_data  = DW'($urandom);
      tick();
    end
    s_valid = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int nv;
    int nd;
    reset = 1'b0; clear = 1'b0; s_valid = 1'b0; s_data = '0; start = 1'b0;
`ifdef COEF_CTRL_REPEAT_EN
    rep_cnt = 3'd0;
`endif
    model_reset();
    tick();
    tick();
    cmp_en = 1'b1;
    // Reset values.
    chk("rst_s_ready", 32'(s_ready), 32'd1);
    chk("rst_bank_en", 32'(bank_en), 32'd0);
    chk("rst_bank_sel", 32'(bank_sel), 32'd0);
    chk("rst_bank_din", 32'(bank_din), 32'd0);
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("rst_loaded", 32'(loaded), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    reset = 1'b1;
    tick();

    // Eight contiguous beats 0x10..0x17.
    for (int i = 0; i < DEPTH; i++) begin
      s_valid = 1'b1;
      s_data  = DW'(8'h10 + i);
      tick();
      chk("load_en", 32'(bank_en), 32'd1);
      chk("load_sel", 32'(bank_sel), 32'(i));
      chk("load_din", 32'(bank_din), 32'(8'h10 + i));
    end
    chk("load_loaded", 32'(loaded), 32'd1);
    chk("full_ready", 32'(s_ready), 32'd0);

    // Drain with s_valid still held: no writes, sel 0..7, done afterwards.
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      chk("drain_valid", 32'(rd_valid), 32'd1);
      chk("drain_sel", 32'(rd_sel), 32'(i));
      chk("drain_no_wr", 32'(bank_en), 32'd0);
      tick();
    end
    chk("done_pulse", 32'(done), 32'd1);
    chk("done_loaded", 32'(loaded), 32'd0);
    chk("done_ready", 32'(s_ready), 32'd1);
    chk("done_rd_valid", 32'(rd_valid), 32'd0);

    // Beat accepted in the done cycle.
    s_data = 8'hA0;
    tick();
    chk("b2b_en", 32'(bank_en), 32'd1);
    chk("b2b_sel", 32'(bank_sel), 32'd0);
    chk("b2b_din", 32'(bank_din), 32'hA0);
    chk("b2b_done_low", 32'(done), 32'd0);

    // Gappy beats: remaining 7 slots on every other cycle.
    for (int i = 0; i < 14; i++) begin
      s_valid = (i % 2 == 0);
      s_data  = DW'($urandom);
      tick();
      if (i % 2 == 0) chk("gap_sel", 32'(bank_sel), 32'(1 + i / 2));
    end
    s_valid = 1'b0;
    chk("gap_loaded", 32'(loaded), 32'd1);
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (DEPTH + 1) tick();

    // start during LOAD is ignored; clear after 5 beats restarts at slot 0.
    for (int i = 0; i < 3; i++) begin
      s_valid = 1'b1; s_data = DW'($urandom); tick();
    end
    s_valid = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    chk("early_start_rd", 32'(rd_valid), 32'd0);
    chk("early_start_busy", 32'(busy), 32'd0);
    for (int i = 0; i < 2; i++) begin
      s_valid = 1'b1; s_data = DW'($urandom); tick();
    end
    clear = 1'b1;
    #1;
    chk("clear_ready", 32'(s_ready), 32'd0);
    tick();
    chk("clear_no_wr", 32'(bank_en), 32'd0);
    clear = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      s_data = DW'($urandom); tick();
      chk("reload_sel", 32'(bank_sel), 32'(i));
    end
    s_valid = 1'b0;
    chk("reload_loaded", 32'(loaded), 32'd1);

    // Asynchronous reset in the middle of a drain.
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    chk("async_rd_valid", 32'(rd_valid), 32'd0);
    chk("async_rd_sel", 32'(rd_sel), 32'd0);
    chk("async_busy", 32'(busy), 32'd0);
    chk("async_loaded", 32'(loaded), 32'd0);
    chk("async_ready", 32'(s_ready), 32'd1);
    tick();
    reset = 1'b1;
    tick();

    // Multi-pass drain (single pass in the default build).
    load_random_set();
`ifdef COEF_CTRL_REPEAT_EN
    rep_cnt = 3'd2;
`endif
    start = 1'b1;
    tick();
    start = 1'b0;
    nv = 0; nd = 0;
    for (int k = 0; k < 40; k++) begin
      if (rd_valid) nv++;
      if (done) nd++;
      tick();
    end
`ifdef COEF_CTRL_REPEAT_EN
    chk("rep_reads", 32'(nv), 32'd24);
`else
    chk("rep_reads", 32'(nv), 32'd8);
`endif
    chk("rep_done_cnt", 32'(nd), 32'd1);

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      clear   = ($urandom_range(0, 49) == 0);
      s_valid = ($urandom_range(0, 2) != 0);
      s_data  = DW'($urandom);
      start   = ($urandom_range(0, 3) == 0);
`ifdef COEF_CTRL_REPEAT_EN
      rep_cnt = 3'($urandom_range(0, 7));
`endif
      tick();
    end
    clear = 1'b0; s_valid = 1'b0; start = 1'b0;
    tick();
    cmp_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
